// File: rtl/fifo_async_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_async_pkg
// Brief   : Shared constants and Gray/binary helpers for the async FIFO
//           pointer controllers.
// Revision: 1.0 - initial release
// ============================================================================
package fifo_async_pkg;

    localparam int MODE_WR = 0;
    localparam int MODE_RD = 1;

    // Widest pointer the helpers handle; callers pass their real width.
    typedef logic [31:0] ptr_word_t;

    // Binary to Gray, bits at or above 'width' forced to zero.
    function automatic ptr_word_t bin2gray(input ptr_word_t b, input int width);
        ptr_word_t g;
        for (int i = 0; i < 32; i++) begin
            g[i] = (i < width) ? (b[i] ^ ((i < width - 1) ? b[(i + 1) % 32] : 1'b0)) : 1'b0;
        end
        return g;
    endfunction

    // Gray to binary by prefix XOR from the MSB of a 'width'-bit code.
    function automatic ptr_word_t gray2bin(input ptr_word_t g, input int width);
        ptr_word_t b;
        logic      acc;
        acc = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            acc  = acc ^ (g[i] & (i < width));
            b[i] = acc;
        end
        return b;
    endfunction

endpackage : fifo_async_pkg
`default_nettype wire

// File: rtl/fifo_async_gtob_cvtr.sv
`default_nettype none
// ============================================================================
// Module  : fifo_async_gtob_cvtr
// Brief   : Combinational Gray-to-binary converter of parametrised width.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_async_gtob_cvtr
    import fifo_async_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign bin[gi] = ^gray[WIDTH-1:gi];
    end

endmodule : fifo_async_gtob_cvtr
`default_nettype wire

// File: rtl/fifo_async_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fifo_async_ptr_ctrl
// Brief   : Per-domain async FIFO pointer/flag controller. Write-side mode
//           produces full flags, read-side mode produces empty flags.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_async_ptr_ctrl
    import fifo_async_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int MODE        = 0,
    parameter int SYNC_STAGES = 2,
    parameter int ALMOST_TH   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic [ADDR_W:0]   rmt_gray,
    output logic [ADDR_W:0]   ptr_gray,
    output logic [ADDR_W-1:0] addr,
    output logic              accept,
    output logic              flag,
    output logic              almost,
    output logic [ADDR_W:0]   level,
    output logic              err
);

    localparam int   c_PW       = ADDR_W + 1;
    localparam logic c_FLAG_RST = (MODE == MODE_RD);

    logic [c_PW-1:0] r_ptr_bin;
    logic [c_PW-1:0] r_ptr_gray;
    logic            r_flag;
    logic            r_almost;
    logic [c_PW-1:0] r_level;
    logic            r_err;

    logic            w_accept;
    logic [c_PW-1:0] w_ptr_bin_nxt;
    logic [c_PW-1:0] w_gray_nxt;
    logic [c_PW-1:0] w_rmt_sync;
    logic [c_PW-1:0] w_rmt_bin;
    logic            w_flag_nxt;
    logic            w_almost_nxt;
    logic [c_PW-1:0] w_level_nxt;

    // Remote Gray pointer synchroniser; every stage is a CDC register.
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        logic [c_PW-1:0] w_d;
        (* ASYNC_REG = "TRUE" *) logic [c_PW-1:0] r_q;
        if (gi == 0) begin : g_head
            assign w_d = rmt_gray;
        end else begin : g_tail
            assign w_d = g_sync[gi-1].r_q;
        end
        // Shift the remote pointer one stage closer to the local domain.
        always_ff @(posedge clk) begin
            if (rst) r_q <= '0;
            else     r_q <= w_d;
        end
    end

    assign w_rmt_sync = g_sync[SYNC_STAGES-1].r_q;

    fifo_async_gtob_cvtr #(
        .WIDTH (c_PW)
    ) u_gtob (
        .gray (w_rmt_sync),
        .bin  (w_rmt_bin)
    );

    assign w_accept      = inc & ~r_flag;
    assign w_ptr_bin_nxt = r_ptr_bin + c_PW'(w_accept);
    assign w_gray_nxt    = c_PW'(bin2gray(32'(w_ptr_bin_nxt), c_PW));

    // Flag, level and almost are all derived from the next local pointer so
    // an accept is reflected on the very edge that takes it.
    if (MODE == MODE_WR) begin : g_wr
        // Full when the next pointer is exactly one lap ahead of the reader:
        // in Gray that is the top two bits inverted.
        localparam logic [c_PW-1:0] c_FULL_XOR  = c_PW'(3 << (ADDR_W - 1));
        localparam logic [c_PW-1:0] c_AFULL_LVL = c_PW'((1 << ADDR_W) - ALMOST_TH);
        assign w_flag_nxt   = (w_gray_nxt == (w_rmt_sync ^ c_FULL_XOR));
        assign w_level_nxt  = w_ptr_bin_nxt - w_rmt_bin;
        assign w_almost_nxt = (w_level_nxt >= c_AFULL_LVL);
    end else begin : g_rd
        localparam logic [c_PW-1:0] c_AEMPTY_LVL = c_PW'(ALMOST_TH);
        assign w_flag_nxt   = (w_gray_nxt == w_rmt_sync);
        assign w_level_nxt  = w_rmt_bin - w_ptr_bin_nxt;
        assign w_almost_nxt = (w_level_nxt <= c_AEMPTY_LVL);
    end

    // Local pointer pair and status registers; refused requests flag an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_bin  <= '0;
            r_ptr_gray <= '0;
            r_flag     <= c_FLAG_RST;
            r_almost   <= c_FLAG_RST;
            r_level    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_ptr_bin  <= w_ptr_bin_nxt;
            r_ptr_gray <= w_gray_nxt;
            r_flag     <= w_flag_nxt;
            r_almost   <= w_almost_nxt;
            r_level    <= w_level_nxt;
            r_err      <= inc & r_flag;
        end
    end

    assign ptr_gray = r_ptr_gray;
    assign addr     = r_ptr_bin[ADDR_W-1:0];
    assign accept   = w_accept;
    assign flag     = r_flag;
    assign almost   = r_almost;
    assign level    = r_level;
    assign err      = r_err;

endmodule : fifo_async_ptr_ctrl
`default_nettype wire

// File: tb/tb_fifo_async_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_async_ptr_ctrl
// Brief   : Self-checking bench: one write-side and one read-side controller
//           (ADDR_W=2) against an occupancy-count reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_async_ptr_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inc_w = 1'b0;
    logic       inc_r = 1'b0;
    int         rmt_cnt [2];
    logic [2:0] rg_w, rg_r;
    logic [2:0] pg_w, pg_r, lvl_w, lvl_r;
    logic [1:0] ad_w, ad_r;
    logic       acc_w, acc_r, fl_w, fl_r, al_w, al_r, er_w, er_r;

    // Reference model: counts of accepted items, remote count seen through a
    // two-edge delay line, and the registered outputs derived from them.
    int loc    [2];
    int dl     [2][2];
    int lvl_m  [2];
    bit flag_m [2];
    bit alm_m  [2];
    bit err_m  [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [2:0] to_gray(input int c);
        logic [2:0] b;
        b = c[2:0];
        return b ^ (b >> 1);
    endfunction

    assign rg_w = to_gray(rmt_cnt[0]);
    assign rg_r = to_gray(rmt_cnt[1]);

    fifo_async_ptr_ctrl #(.ADDR_W(2), .MODE(0), .SYNC_STAGES(2), .ALMOST_TH(1)) u_wr (
        .clk(clk), .rst(rst), .inc(inc_w), .rmt_gray(rg_w), .ptr_gray(pg_w),
        .addr(ad_w), .accept(acc_w), .flag(fl_w), .almost(al_w), .level(lvl_w), .err(er_w)
    );

    fifo_async_ptr_ctrl #(.ADDR_W(2), .MODE(1), .SYNC_STAGES(2), .ALMOST_TH(1)) u_rd (
        .clk(clk), .rst(rst), .inc(inc_r), .rmt_gray(rg_r), .ptr_gray(pg_r),
        .addr(ad_r), .accept(acc_r), .flag(fl_r), .almost(al_r), .level(lvl_r), .err(er_r)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int m, input logic inc_v, input logic rst_v);
        int seen, d;
        if (rst_v) begin
            loc[m] = 0; dl[m][0] = 0; dl[m][1] = 0;
            flag_m[m] = (m == 1); alm_m[m] = (m == 1);
            lvl_m[m] = 0; err_m[m] = 1'b0;
        end else begin
            err_m[m] = inc_v && flag_m[m];
            if (inc_v && !flag_m[m]) loc[m]++;
            seen     = dl[m][1];
            dl[m][1] = dl[m][0];
            dl[m][0] = rmt_cnt[m];
            d        = (m == 0) ? (loc[m] - seen) : (seen - loc[m]);
            lvl_m[m] = d & 7;
            flag_m[m] = (m == 0) ? (lvl_m[m] == 4) : (lvl_m[m] == 0);
            alm_m[m]  = (m == 0) ? (lvl_m[m] >= 3) : (lvl_m[m] <= 1);
        end
    endtask

    task automatic check_all();
        chk("wr_gray",   pg_w,  to_gray(loc[0]));
        chk("wr_addr",   ad_w,  loc[0] & 3);
        chk("wr_flag",   fl_w,  flag_m[0]);
        chk("wr_almost", al_w,  alm_m[0]);
        chk("wr_level",  lvl_w, lvl_m[0]);
        chk("wr_err",    er_w,  err_m[0]);
        chk("rd_gray",   pg_r,  to_gray(loc[1]));
        chk("rd_addr",   ad_r,  loc[1] & 3);
        chk("rd_flag",   fl_r,  flag_m[1]);
        chk("rd_almost", al_r,  alm_m[1]);
        chk("rd_level",  lvl_r, lvl_m[1]);
        chk("rd_err",    er_r,  err_m[1]);
    endtask

    // One clock: check the combinational accept, take the edge, update the
    // model and compare every registered output.
    task automatic cycle();
        #1;
        chk("wr_accept", acc_w, inc_w & ~flag_m[0]);
        chk("rd_accept", acc_r, inc_r & ~flag_m[1]);
        @(posedge clk);
        model_edge(0, inc_w, rst);
        model_edge(1, inc_r, rst);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; inc_w = 1'b0; inc_r = 1'b0;
        rmt_cnt[0] = 0; rmt_cnt[1] = 0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rmt_cnt[0] = 0; rmt_cnt[1] = 0;

        // Reset values for both modes
        @(posedge clk);
        @(posedge clk);
        model_edge(0, 1'b0, 1'b1);
        model_edge(1, 1'b0, 1'b1);
        #1;
        check_all();
        chk("rst_wr_gray", pg_w, 3'b000);
        chk("rst_rd_flag", fl_r, 1'b1);
        chk("rst_rd_almost", al_r, 1'b1);
        rst = 1'b0;

        // Fill the write side with the reader parked at zero
        inc_w = 1'b1;
        repeat (4) cycle();
        chk("fill_gray", pg_w, 3'b110);
        chk("fill_flag", fl_w, 1'b1);
        chk("fill_level", lvl_w, 3'd4);
        cycle();
        chk("ovf_err", er_w, 1'b1);
        chk("ovf_gray_hold", pg_w, 3'b110);
        inc_w = 1'b0;
        cycle();
        chk("ovf_err_clear", er_w, 1'b0);

        // Drain the read side after the writer jumps to 4 entries
        rmt_cnt[1] = 4;
        cycle();
        chk("drain_flag_e1", fl_r, 1'b1);
        cycle();
        chk("drain_flag_e2", fl_r, 1'b1);
        cycle();
        chk("drain_flag_e3", fl_r, 1'b0);
        chk("drain_level", lvl_r, 3'd4);
        inc_r = 1'b1;
        repeat (4) cycle();
        chk("drain_empty", fl_r, 1'b1);
        chk("drain_level0", lvl_r, 3'd0);
        cycle();
        chk("udf_err", er_r, 1'b1);
        inc_r = 1'b0;
        cycle();
        chk("udf_err_clear", er_r, 1'b0);

        // Wrap-around with the reader following
        do_reset();
        inc_w = 1'b1;
        repeat (7) begin
            cycle();
            rmt_cnt[0] = loc[0];
        end
        chk("wrap_gray_pre", pg_w, 3'b100);
        chk("wrap_addr_pre", ad_w, 2'd3);
        cycle();
        chk("wrap_gray_post", pg_w, 3'b000);
        chk("wrap_addr_post", ad_w, 2'd0);
        inc_w = 1'b0;
        rmt_cnt[0] = loc[0];
        repeat (3) cycle();

        // Almost-full threshold crossing
        do_reset();
        inc_w = 1'b1;
        repeat (2) cycle();
        chk("alm_lvl2", al_w, 1'b0);
        cycle();
        chk("alm_rise_lvl", lvl_w, 3'd3);
        chk("alm_rise", al_w, 1'b1);
        inc_w = 1'b0;
        rmt_cnt[0] = 1;
        repeat (2) cycle();
        chk("alm_hold", al_w, 1'b1);
        cycle();
        chk("alm_fall_lvl", lvl_w, 3'd2);
        chk("alm_fall", al_w, 1'b0);

        // Reset mid-operation with a push pending
        inc_w = 1'b1;
        cycle();
        chk("mid_lvl3", lvl_w, 3'd3);
        rst = 1'b1; inc_r = 1'b1;
        rmt_cnt[0] = 0; rmt_cnt[1] = 0;
        cycle();
        chk("mid_gray", pg_w, 3'b000);
        chk("mid_level", lvl_w, 3'd0);
        chk("mid_flag", fl_w, 1'b0);
        chk("mid_rd_flag", fl_r, 1'b1);
        rst = 1'b0; inc_w = 1'b0; inc_r = 1'b0;

        // Randomised traffic; remote sides move only within legal bounds
        for (int i = 0; i < 3000; i++) begin
            int p;
            p = ((i / 250) % 2 != 0) ? 3 : 1;
            rst   = ($urandom_range(0, 299) == 0);
            inc_w = ($urandom_range(0, 3) < p);
            inc_r = ($urandom_range(0, 3) < 4 - p);
            if (rst) begin
                rmt_cnt[0] = 0;
                rmt_cnt[1] = 0;
            end else begin
                if (rmt_cnt[0] < loc[0] && $urandom_range(0, 3) < 4 - p) rmt_cnt[0]++;
                if (rmt_cnt[1] - loc[1] < 4 && $urandom_range(0, 3) < p) rmt_cnt[1]++;
            end
            cycle();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fifo_async_ptr_ctrl
`default_nettype wire

// File: doc/fifo_async_ptr_ctrl.md
# fifo_async_ptr_ctrl

- Parametrised per-domain pointer/flag controller for the asynchronous FIFOs in the SDRAM controller. One instance sits in each clock domain of a FIFO:
  - write-side mode: produces the full flags;
  - read-side mode: produces the empty flags.
- It owns the local binary/Gray pointer pair, synchronises the remote Gray pointer into its own clock, converts it back to binary, and derives the status flags, fill level and overflow/underflow errors.

## Interface
- `ADDR_W`, default 4: RAM address width; depth = 2^ADDR_W; pointers are ADDR_W+1 bits.
- `MODE`, default 0: 0 = write side (full flags), 1 = read side (empty flags).
- `SYNC_STAGES`, default 2: flops in the remote-pointer synchroniser; legal range 2..4.
- `ALMOST_TH`, default 1: almost-flag threshold, 0..2^ADDR_W-1.

Ports:
- `clk` in 1: local domain clock.
- `rst` in 1: synchronous reset, active-high.
- `inc` in 1: push (MODE 0) or pop (MODE 1) request.
- `rmt_gray` in ADDR_W+1: remote-domain Gray pointer; asynchronous to `clk`.
- `ptr_gray` out ADDR_W+1: registered local Gray pointer, exported to the other domain.
- `addr` out ADDR_W: RAM address, equal to `ptr_bin[ADDR_W-1:0]`.
- `accept` out 1: combinational, `inc & ~flag`.
- `flag` out 1: full (MODE 0) or empty (MODE 1), registered.
- `almost` out 1: almost_full (MODE 0) or almost_empty (MODE 1), registered.
- `level` out ADDR_W+1: registered occupancy, 0..2^ADDR_W.
- `err` out 1: one-cycle pulse; overflow (MODE 0) or underflow (MODE 1).

## Operation
- Pointer update:
  - `ptr_bin_nxt = ptr_bin + accept`, modulo 2^(ADDR_W+1).
  - `gray_nxt = ptr_bin_nxt ^ (ptr_bin_nxt >> 1)`.
  - Both pointers are registered on every clock.
- Synchroniser: `rmt_gray` passes through SYNC_STAGES flops, giving `rmt_sync`. `rmt_bin` is the prefix-XOR Gray-to-binary conversion of `rmt_sync`.
- Flag, from the next pointer:
  - MODE 0: full_nxt = (`gray_nxt` == {~`rmt_sync`[ADDR_W:ADDR_W-1], `rmt_sync`[ADDR_W-2:0]}).
  - MODE 1: empty_nxt = (`gray_nxt` == `rmt_sync`).
- Level, from the next pointer, modulo 2^(ADDR_W+1):
  - MODE 0: `level_nxt = ptr_bin_nxt − rmt_bin`.
  - MODE 1: `level_nxt = rmt_bin − ptr_bin_nxt`.
- Almost flag:
  - MODE 0: `almost_nxt = level_nxt >= 2^ADDR_W − ALMOST_TH`.
  - MODE 1: `almost_nxt = level_nxt <= ALMOST_TH`.
- Error: `err` is set next cycle when `inc & flag`. A refused request does not move the pointer.
- Reset values:
  - `ptr_bin`, `ptr_gray`, `addr`, `level`, `err` and all synchroniser stages are 0.
  - MODE 0: `flag`=0, `almost`=0 (assumes ALMOST_TH < 2^ADDR_W).
  - MODE 1: `flag`=1, `almost`=1.
- Reset mid-operation returns every register to its reset value on that edge, regardless of `inc`. The two domains must be reset together; the block does not resynchronise reset.
- Wrap-around: the pointer MSB toggles every 2^ADDR_W accepts. `ptr_gray` changes exactly one bit per accept, including at the 2^(ADDR_W+1)−1 → 0 wrap.

## Timing
- A request with `inc` high in cycle n and `flag` low in cycle n is accepted. On edge n+1, `ptr_bin`, `ptr_gray`, `flag`, `almost` and `level` all reflect it. Zero-bubble back-to-back accepts.
- A change on `rmt_gray` is first visible in `flag`/`level`/`almost` SYNC_STAGES+1 edges later. Flags are therefore conservative: full/empty may deassert late, never early.
- If a local accept and a remote pointer change arrive in the same cycle, both are reflected in the same registered update.
- `err` asserts for exactly one cycle per refused request, on edge n+1.

## Structure
- Package `fifo_async_pkg` holds:
  - functions `bin2gray` and `gray2bin`, parametrised by width;
  - constants `MODE_WR`=0 and `MODE_RD`=1.
- Sub-module `fifo_async_gtob_cvtr`: parametrised combinational Gray-to-binary converter, used on `rmt_sync`.
- Synchroniser is inline in a generate loop, with the register chain marked for CDC/ASYNC_REG constraints.

## Test plan
- Reset, ADDR_W=2, both modes:
  - MODE 0 -> `ptr_gray`=000, `flag`=0, `level`=0.
  - MODE 1 -> `flag`=1, `almost`=1.
- Fill, MODE 0, ADDR_W=2, `rmt_gray` held at 000, 4 consecutive pushes:
  - after the 4th push, `ptr_bin`=100, `ptr_gray`=110, `flag`=1, `level`=4;
  - a 5th push gives `accept`=0, `err` pulses one cycle, pointer unchanged.
- Drain, MODE 1, `rmt_gray` stepped to 110 (4 entries):
  - `flag` falls SYNC_STAGES+1 edges later;
  - 4 pops -> `flag`=1, `level`=0;
  - a further pop -> `err` pulse.
- Wrap, MODE 0: 7 accepts with the remote pointer following, then one more -> `ptr_bin` goes 111→000, `ptr_gray` goes 100→000 (single-bit change), `addr` goes 3→0.
- Almost, MODE 0, ADDR_W=2, ALMOST_TH=1: `almost` rises on the edge where `level` becomes 3 and falls when `level` returns to 2.
- Reset mid-operation: assert `rst` with `level`=3 and `inc`=1 -> next edge all outputs at reset values, push ignored.
